tone_mixer: RTL

Downstream audio stage for the seven-voice square-wave tone generator. It takes the seven per-note square waves and the seven note-enable switches and sums the active voices into one 8-bit level. It applies a linear attack/release envelope to that level and drives a single speaker pin with fixed-period PWM, replacing the seven separate speaker pins with one audio output.

---
 rtl/tone_mixer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/tone_mixer.sv
// -----------------------------------------------------------------------------
// tone_mixer
//
// Audio back end for the seven-voice square-wave tone generator. It adds up
// the seven square waves into one 8-bit level and shapes that level with a
// linear attack/release envelope. The result drives a single speaker pin
// through fixed-period (256-cycle) PWM.
//
// Parameters
//   ENV_STEP_CYCLES : clock cycles between envelope gain updates (>= 2)
//   ATTACK_STEP     : gain increment per envelope tick while any voice is on
//   RELEASE_STEP    : gain decrement per envelope tick while all voices are off
//
// Ports
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   tone_in   in   7  per-voice square waves, bit i = voice i
//   voice_en  in   7  note-enable switches, same bit order as tone_in
//   pwm_out   out  1  PWM audio to the speaker (registered)
//   level     out  8  scaled level before PWM (registered, debug)
//   env_state out  2  envelope state: 0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE
// -----------------------------------------------------------------------------
module tone_mixer #(
    parameter int unsigned ENV_STEP_CYCLES = 4096,
    parameter int unsigned ATTACK_STEP     = 1,
    parameter int unsigned RELEASE_STEP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] tone_in,
    input  logic [6:0] voice_en,
    output logic       pwm_out,
    output logic [7:0] level,
    output logic [1:0] env_state
);

    localparam int unsigned       TICK_W     = $clog2(ENV_STEP_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ENV_STEP_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [8:0]        ATTACK_INC = 9'(ATTACK_STEP);
    localparam logic [8:0]        RELEASE_DEC = 9'(RELEASE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    // Number of set bits in a 7-bit vector (0..7).
    function automatic logic [2:0] f_popcount7(input logic [6:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Gain + step, clamped at 255. The carry out of the 9-bit sum flags overflow.
    function automatic logic [7:0] f_sat_add(input logic [7:0] g, input logic [8:0] step);
        logic [8:0] s;
        s = {1'b0, g} + step;
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Gain - step, clamped at 0. The borrow into bit 8 flags underflow.
    function automatic logic [7:0] f_sat_sub(input logic [7:0] g, input logic [8:0] step);
        logic [8:0] d;
        d = {1'b0, g} - step;
        return d[8] ? 8'h00 : d[7:0];
    endfunction

    // Registers
    logic [6:0]        r_tone_q;
    logic [6:0]        r_en_q;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [7:0]        r_gain;
    env_state_t        r_state;
    logic [7:0]        r_level;
    logic [7:0]        r_duty;
    logic [7:0]        r_pwm_cnt;
    logic              r_pwm_out;

    // Combinational nets
    logic        w_any_on;
    logic        w_tick;
    logic [2:0]  w_sum;
    logic [7:0]  w_sample;
    logic [15:0] w_product;
    logic [7:0]  w_gain_nxt;
    env_state_t  w_state_nxt;

    assign w_any_on  = |r_en_q;
    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_sum     = f_popcount7(r_tone_q);
    // sum * 36 = sum * 32 + sum * 4; 7 * 36 = 252 fits in 8 bits
    assign w_sample  = {w_sum, 5'b0_0000} + {3'b000, w_sum, 2'b00};
    assign w_product = {8'h00, w_sample} * {8'h00, r_gain};

    // Input capture: everything downstream works from these registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_q <= 7'd0;
            r_en_q   <= 7'd0;
        end else begin
            r_tone_q <= tone_in;
            r_en_q   <= voice_en;
        end
    end

    // Free-running envelope tick counter, 0..ENV_STEP_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_ONE;
        end
    end

    // Next gain: moves only on a tick; direction follows voice activity, not FSM state.
    always_comb begin
        w_gain_nxt = r_gain;
        if (!w_tick) begin
            w_gain_nxt = r_gain;
        end else if (w_any_on) begin
            w_gain_nxt = f_sat_add(r_gain, ATTACK_INC);
        end else begin
            w_gain_nxt = f_sat_sub(r_gain, RELEASE_DEC);
        end
    end

    // Gain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain <= 8'd0;
        end else begin
            r_gain <= w_gain_nxt;
        end
    end

    // Envelope next-state: decisions use the gain held before this edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_on) begin
                    w_state_nxt = ST_ATTACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ATTACK: begin
                if (!w_any_on) begin
                    w_state_nxt = ST_RELEASE;
                end else if (r_gain == 8'hFF) begin
                    w_state_nxt = ST_SUSTAIN;
                end else begin
                    w_state_nxt = ST_ATTACK;
                end
            end
            ST_SUSTAIN: begin
                if (!w_any_on) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_SUSTAIN;
                end
            end
            ST_RELEASE: begin
                if (w_any_on) begin
                    w_state_nxt = ST_ATTACK;
                end else if (r_gain == 8'h00) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Envelope state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scaled level: upper byte of sample * gain (at most 252 * 255 >> 8 = 251).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 8'd0;
        end else begin
            r_level <= w_product[15:8];
        end
    end

    // PWM counter and duty latch; duty is taken only at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'd0;
            r_duty    <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (r_pwm_cnt == 8'hFF) begin
                r_duty <= r_level;
            end else begin
                r_duty <= r_duty;
            end
        end
    end

    // PWM comparator output; duty 0 yields a constant low, 255 is 255/256 high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_out <= (r_pwm_cnt < r_duty);
        end
    end

    assign pwm_out   = r_pwm_out;
    assign level     = r_level;
    assign env_state = r_state;

endmodule
